linear_layer_start_fifo: RTL and testbench

Shift-register FIFO controller that carries start tokens from a Linear_Layer_i4xi4_q dispatcher to a downstream PE_i4xi4_pack instance. It tracks occupancy and drives the full/empty handshakes. It owns a small SRL-style storage array that always shifts on write and is read at a pointer-selected tap. One instance sits on every producer-to-PE start channel; it decouples the producer's start from the PE's start by up to DEPTH tokens.

---
 rtl/linear_layer_fifo_pkg.sv | 19 +
 rtl/linear_layer_start_fifo_srl.sv | 36 +++
 rtl/linear_layer_start_fifo.sv | 95 +++++++++
 tb/tb_linear_layer_start_fifo.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/linear_layer_fifo_pkg.sv
// Shared definitions for the Linear_Layer start-token FIFOs.
//   - PTR_EMPTY   : all-ones pointer value meaning "no entries"; callers
//                   take the low ptr_width() bits.
//   - ptr_width() : pointer width rule, one bit wider than the tap address
//                   so that -1 can be represented.
//   - depth_legal(): elaboration-time legality of DEPTH for an ADDR_WIDTH.
package linear_layer_fifo_pkg;

    localparam logic [64:0] PTR_EMPTY = '1;

    function automatic int ptr_width(input int addr_w);
        return addr_w + 1;
    endfunction

    function automatic bit depth_legal(input int depth, input int addr_w);
        return (depth >= 2) && (depth <= (1 << addr_w));
    endfunction

endpackage

// File: rtl/linear_layer_start_fifo_srl.sv
// Shift-register storage for the start-token FIFO. No reset.
// Ports:
//   clk        : clock
//   i_shift_en : shift every entry up one place and load i_din into entry 0
//   i_addr     : read tap address
//   i_din      : write data
//   o_dout     : entry at i_addr (combinational)
module linear_layer_start_fifo_srl #(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  i_shift_en,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_din,
    output logic [DATA_WIDTH-1:0] o_dout
);

    // Sized to the full tap address range so every address is in bounds;
    // entries at or above DEPTH are never read while data is valid.
    localparam int SIZE = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [SIZE];

    always_ff @(posedge clk) begin
        if (i_shift_en) begin
            r_mem[0] <= i_din;
            for (int i = 1; i < SIZE; i++) begin
                r_mem[i] <= r_mem[i-1];
            end
        end
    end

    assign o_dout = r_mem[i_addr];

endmodule

// File: rtl/linear_layer_start_fifo.sv
// Start-token FIFO between a Linear_Layer dispatcher and a PE instance.
// Tracks occupancy with a two's-complement pointer (-1 = empty) and drives
// registered full/empty handshakes; data lives in a shift-register array
// read at the pointer tap (first-word-fall-through).
// Ports:
//   ap_clk, ap_rst_n      : clock, synchronous active-low reset
//   if_write, if_din      : producer write request and data
//   if_full_n             : space available (registered)
//   if_read               : consumer read request
//   if_dout               : head-of-queue data, valid while if_empty_n=1
//   if_empty_n            : head data valid (registered)
//   if_num_data_valid     : occupancy 0..DEPTH (registered)
module linear_layer_start_fifo
    import linear_layer_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 1,
    parameter int DEPTH      = 2
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_full_n,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic                  if_empty_n,
    output logic [ADDR_WIDTH:0]   if_num_data_valid
);

    localparam int PTR_W = ptr_width(ADDR_WIDTH);
    localparam logic [PTR_W-1:0] PTR_RST       = PTR_EMPTY[PTR_W-1:0];
    localparam logic [PTR_W-1:0] PTR_ONE       = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_ZERO      = '0;
    localparam logic [PTR_W-1:0] PTR_NEAR_FULL = PTR_W'(DEPTH - 2);

    if (!depth_legal(DEPTH, ADDR_WIDTH)) begin : g_bad_depth
        $error("linear_layer_start_fifo: DEPTH must be in 2..2**ADDR_WIDTH");
    end

    logic [PTR_W-1:0]      r_ptr;
    logic [PTR_W-1:0]      r_num;
    logic                  r_full_n;
    logic                  r_empty_n;
    logic                  w_push;
    logic                  w_pop;
    logic [DATA_WIDTH-1:0] w_dout;

    // Requests are qualified by the registered flags, so a write while
    // full or a read while empty is simply dropped.
    assign w_push = if_write & r_full_n & ap_rst_n;
    assign w_pop  = if_read  & r_empty_n & ap_rst_n;

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            r_ptr     <= PTR_RST;
            r_num     <= PTR_ZERO;
            r_full_n  <= 1'b1;
            r_empty_n <= 1'b0;
        end else if (w_push && !w_pop) begin
            r_ptr     <= r_ptr + PTR_ONE;
            r_num     <= r_num + PTR_ONE;
            r_empty_n <= 1'b1;
            if (r_ptr == PTR_NEAR_FULL) begin
                r_full_n <= 1'b0;
            end
        end else if (w_pop && !w_push) begin
            r_ptr    <= r_ptr - PTR_ONE;
            r_num    <= r_num - PTR_ONE;
            r_full_n <= 1'b1;
            if (r_ptr == PTR_ZERO) begin
                r_empty_n <= 1'b0;
            end
        end
        // Push and pop together: the shift alone advances the head, so the
        // pointer and flags hold.
    end

    linear_layer_start_fifo_srl #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_srl (
        .clk        (ap_clk),
        .i_shift_en (w_push),
        .i_addr     (r_ptr[ADDR_WIDTH-1:0]),
        .i_din      (if_din),
        .o_dout     (w_dout)
    );

    assign if_dout           = w_dout;
    assign if_full_n         = r_full_n;
    assign if_empty_n        = r_empty_n;
    assign if_num_data_valid = r_num;

endmodule

// File: tb/tb_linear_layer_start_fifo.sv
module tb_linear_layer_start_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // DEPTH=2, DATA_WIDTH=1 instance
    logic       rst_n2 = 1'b0;
    logic       wr2 = 1'b0, rd2 = 1'b0, din2 = 1'b0;
    logic       full_n2, dout2, empty_n2;
    logic [1:0] num2;

    // DEPTH=4, DATA_WIDTH=8 instance
    logic       rst_n4 = 1'b0;
    logic       wr4 = 1'b0, rd4 = 1'b0;
    logic [7:0] din4 = '0;
    logic       full_n4, empty_n4;
    logic [7:0] dout4;
    logic [2:0] num4;

    linear_layer_start_fifo #(.DATA_WIDTH(1), .ADDR_WIDTH(1), .DEPTH(2)) u_dut2 (
        .ap_clk            (clk),
        .ap_rst_n          (rst_n2),
        .if_write          (wr2),
        .if_din            (din2),
        .if_full_n         (full_n2),
        .if_read           (rd2),
        .if_dout           (dout2),
        .if_empty_n        (empty_n2),
        .if_num_data_valid (num2)
    );

    linear_layer_start_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .DEPTH(4)) u_dut4 (
        .ap_clk            (clk),
        .ap_rst_n          (rst_n4),
        .if_write          (wr4),
        .if_din            (din4),
        .if_full_n         (full_n4),
        .if_read           (rd4),
        .if_dout           (dout4),
        .if_empty_n        (empty_n4),
        .if_num_data_valid (num4)
    );

    // Reference models: occupancy counters and scoreboard queues.
    int         m2_cnt = 0;
    int         m4_cnt = 0;
    logic       sb2[$];
    logic [7:0] sb4[$];

    logic       popped2, pop_act2, pop_exp2;
    logic       popped4;
    logic [7:0] pop_act4, pop_exp4;

    // Occupancy must never exceed capacity (pointer stays in -1..DEPTH-1).
    always @(negedge clk) begin
        if (rst_n4 && num4 > 3'd4) begin
            errors++;
            $display("FAIL occ_bound4: num=%0d limit=4", num4);
        end
        if (rst_n2 && num2 > 2'd2) begin
            errors++;
            $display("FAIL occ_bound2: num=%0d limit=2", num2);
        end
    end

    // One clock of stimulus on the DEPTH=4 instance; records the head seen
    // on an effective pop along with the scoreboard's expectation.
    task automatic drive4(input logic wr, input logic rd, input logic [7:0] d);
        logic pushed;
        wr4 = wr; rd4 = rd; din4 = d;
        #1;
        pushed  = wr && (m4_cnt < 4);
        popped4 = rd && (m4_cnt > 0);
        if (popped4) begin
            pop_act4 = dout4;
            pop_exp4 = sb4.pop_front();
        end
        @(posedge clk); #1;
        if (pushed) sb4.push_back(d);
        m4_cnt = m4_cnt + int'(pushed) - int'(popped4);
        wr4 = 1'b0; rd4 = 1'b0;
    endtask

    task automatic drive2(input logic wr, input logic rd, input logic d);
        logic pushed;
        wr2 = wr; rd2 = rd; din2 = d;
        #1;
        pushed  = wr && (m2_cnt < 2);
        popped2 = rd && (m2_cnt > 0);
        if (popped2) begin
            pop_act2 = dout2;
            pop_exp2 = sb2.pop_front();
        end
        @(posedge clk); #1;
        if (pushed) sb2.push_back(d);
        m2_cnt = m2_cnt + int'(pushed) - int'(popped2);
        wr2 = 1'b0; rd2 = 1'b0;
    endtask

    task automatic test_reset();
        rst_n2 = 1'b0; rst_n4 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n2 = 1'b1; rst_n4 = 1'b1;
        m2_cnt = 0; m4_cnt = 0; sb2.delete(); sb4.delete();
        for (int i = 0; i < 5; i++) begin
            drive4(1'b0, 1'b1, 8'h00);
            drive2(1'b0, 1'b1, 1'b0);
            checks++;
            if (empty_n4 !== 1'b0 || full_n4 !== 1'b1 || num4 !== 3'd0) begin
                errors++;
                $display("FAIL reset_idle4 cyc%0d: empty_n=%b full_n=%b num=%0d want 0 1 0",
                         i, empty_n4, full_n4, num4);
            end
            checks++;
            if (empty_n2 !== 1'b0 || full_n2 !== 1'b1 || num2 !== 2'd0) begin
                errors++;
                $display("FAIL reset_idle2 cyc%0d: empty_n=%b full_n=%b num=%0d want 0 1 0",
                         i, empty_n2, full_n2, num2);
            end
        end
    endtask

    task automatic test_depth2();
        drive2(1'b1, 1'b0, 1'b1);
        checks++;
        if (empty_n2 !== 1'b1 || dout2 !== 1'b1) begin
            errors++;
            $display("FAIL d2_first_push: empty_n=%b dout=%b want 1 1", empty_n2, dout2);
        end
        drive2(1'b1, 1'b0, 1'b0);
        checks++;
        if (full_n2 !== 1'b0 || num2 !== 2'd2) begin
            errors++;
            $display("FAIL d2_full: full_n=%b num=%0d want 0 2", full_n2, num2);
        end
        drive2(1'b0, 1'b1, 1'b0);
        checks++;
        if (!popped2 || pop_act2 !== pop_exp2 || pop_act2 !== 1'b1) begin
            errors++;
            $display("FAIL d2_pop1: got=%b want=1", pop_act2);
        end
        drive2(1'b0, 1'b1, 1'b0);
        checks++;
        if (!popped2 || pop_act2 !== pop_exp2 || pop_act2 !== 1'b0) begin
            errors++;
            $display("FAIL d2_pop2: got=%b want=0", pop_act2);
        end
        checks++;
        if (empty_n2 !== 1'b0 || full_n2 !== 1'b1 || num2 !== 2'd0) begin
            errors++;
            $display("FAIL d2_drained: empty_n=%b full_n=%b num=%0d want 0 1 0",
                     empty_n2, full_n2, num2);
        end
    endtask

    task automatic test_full_ignore();
        logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) drive4(1'b1, 1'b0, vals[i]);
        checks++;
        if (full_n4 !== 1'b0 || num4 !== 3'd4 || empty_n4 !== 1'b1) begin
            errors++;
            $display("FAIL full4: full_n=%b num=%0d empty_n=%b want 0 4 1",
                     full_n4, num4, empty_n4);
        end
        drive4(1'b1, 1'b0, 8'h55);
        checks++;
        if (num4 !== 3'd4 || full_n4 !== 1'b0) begin
            errors++;
            $display("FAIL write_when_full: num=%0d full_n=%b want 4 0", num4, full_n4);
        end
        for (int i = 0; i < 4; i++) begin
            drive4(1'b0, 1'b1, 8'h00);
            checks++;
            if (!popped4 || pop_act4 !== vals[i] || pop_act4 !== pop_exp4) begin
                errors++;
                $display("FAIL full_drain%0d: got=%h want=%h", i, pop_act4, vals[i]);
            end
        end
        checks++;
        if (empty_n4 !== 1'b0 || full_n4 !== 1'b1 || num4 !== 3'd0) begin
            errors++;
            $display("FAIL full_drained: empty_n=%b full_n=%b num=%0d want 0 1 0",
                     empty_n4, full_n4, num4);
        end
    endtask

    task automatic test_back_to_back();
        drive4(1'b1, 1'b0, 8'hA0);
        for (int i = 0; i < 20; i++) begin
            logic [7:0] want;
            want = (i == 0) ? 8'hA0 : 8'(i);
            drive4(1'b1, 1'b1, 8'(i + 1));
            checks++;
            if (num4 !== 3'd1 || empty_n4 !== 1'b1 || full_n4 !== 1'b1) begin
                errors++;
                $display("FAIL b2b_flags%0d: num=%0d empty_n=%b full_n=%b want 1 1 1",
                         i, num4, empty_n4, full_n4);
            end
            checks++;
            if (!popped4 || pop_act4 !== want || pop_act4 !== pop_exp4) begin
                errors++;
                $display("FAIL b2b_data%0d: got=%h want=%h", i, pop_act4, want);
            end
        end
        drive4(1'b0, 1'b1, 8'h00);
        checks++;
        if (pop_act4 !== 8'd20 || empty_n4 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_tail: got=%h empty_n=%b want 14 0", pop_act4, empty_n4);
        end
    endtask

    task automatic test_full_simul();
        for (int i = 0; i < 4; i++) drive4(1'b1, 1'b0, 8'hC0 + 8'(i));
        drive4(1'b1, 1'b1, 8'h99);
        checks++;
        if (num4 !== 3'd3 || full_n4 !== 1'b1) begin
            errors++;
            $display("FAIL full_simul: num=%0d full_n=%b want 3 1", num4, full_n4);
        end
        checks++;
        if (!popped4 || pop_act4 !== 8'hC0) begin
            errors++;
            $display("FAIL full_simul_data: got=%h want=c0", pop_act4);
        end
        for (int i = 0; i < 3; i++) begin
            drive4(1'b0, 1'b1, 8'h00);
            checks++;
            if (pop_act4 !== pop_exp4 || pop_act4 !== 8'hC1 + 8'(i)) begin
                errors++;
                $display("FAIL full_simul_drain%0d: got=%h want=%h", i, pop_act4, 8'hC1 + 8'(i));
            end
        end
        drive4(1'b1, 1'b1, 8'h5A);
        checks++;
        if (num4 !== 3'd1 || empty_n4 !== 1'b1 || dout4 !== 8'h5A) begin
            errors++;
            $display("FAIL empty_simul: num=%0d empty_n=%b dout=%h want 1 1 5a",
                     num4, empty_n4, dout4);
        end
        drive4(1'b0, 1'b1, 8'h00);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) drive4(1'b1, 1'b0, 8'h30 + 8'(i));
        checks++;
        if (num4 !== 3'd3) begin
            errors++;
            $display("FAIL pre_reset_count: num=%0d want 3", num4);
        end
        rst_n4 = 1'b0; wr4 = 1'b1; din4 = 8'hEE;
        @(posedge clk); #1;
        rst_n4 = 1'b1; wr4 = 1'b0;
        m4_cnt = 0; sb4.delete();
        checks++;
        if (num4 !== 3'd0 || empty_n4 !== 1'b0 || full_n4 !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid: num=%0d empty_n=%b full_n=%b want 0 0 1",
                     num4, empty_n4, full_n4);
        end
        drive4(1'b1, 1'b0, 8'h7E);
        checks++;
        if (empty_n4 !== 1'b1 || dout4 !== 8'h7E || num4 !== 3'd1) begin
            errors++;
            $display("FAIL post_reset_push: empty_n=%b dout=%h num=%0d want 1 7e 1",
                     empty_n4, dout4, num4);
        end
    endtask

    initial begin
        test_reset();
        test_depth2();
        test_full_ignore();
        test_back_to_back();
        test_full_simul();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
